// File: rtl/ram_dp_port_arbiter.sv
// ram_dp_port_arbiter
// Round-robin arbiter that shares one port of a registered-address 1024x32 RAM
// between two single-clock requesters. Requests use a req/gnt handshake with a
// combinational grant; read data returns two edges after acceptance, tagged to
// the requester that issued it.
//
// Optional feature, macro RAM_ARB_INIT_EN: after every reset the arbiter first
// writes INIT_VALUE to every address (one per cycle) and only then enables
// arbitration (init_done_o rises). Without the macro, arbitration starts right
// after reset and init_done_o is tied high.
module ram_dp_port_arbiter #(
    parameter int unsigned       ADDR_W     = 10,
    parameter int unsigned       DATA_W     = 32,
    parameter logic [DATA_W-1:0] INIT_VALUE = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,

    // Requester 0
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,

    // Requester 1
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,

    output logic              init_done_o,

    // RAM port
    output logic              ram_we_o,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_din_o,
    input  logic [DATA_W-1:0] ram_dout_i
);

    logic              run;        // arbitration enabled
    logic              init_wr;    // clear-sequence write this cycle
    logic [ADDR_W-1:0] init_addr;  // clear-sequence address

    logic              gnt0;
    logic              gnt1;

    logic              last_q;     // index of the most recently granted requester
    logic              pend_vld_q; // read accepted on the previous edge
    logic              pend_id_q;  // which requester that read belongs to
    logic [ADDR_W-1:0] ram_addr_q; // last driven address, held while idle
    logic [DATA_W-1:0] ram_din_q;  // last driven write data, held while idle

    logic              rvalid0_q;
    logic              rvalid1_q;
    logic [DATA_W-1:0] rdata0_q;
    logic [DATA_W-1:0] rdata1_q;

`ifdef RAM_ARB_INIT_EN
    typedef enum logic [0:0] {
        StInit,
        StRun
    } state_e;

    state_e            state_q;
    state_e            state_d;
    logic [ADDR_W-1:0] cnt_q;
    logic [ADDR_W-1:0] cnt_d;

    // State register and clear-address counter; every reset restarts the clear
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StInit;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: write each address once, then hand the port to the requesters
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_wr = 1'b0;
        case (state_q)
            StInit: begin
                init_wr = 1'b1;
                cnt_d   = cnt_q + ADDR_W'(1);
                if (cnt_q == {ADDR_W{1'b1}}) begin
                    state_d = StRun;
                end
            end
            default: begin
            end
        endcase
    end

    assign run         = (state_q == StRun);
    assign init_addr   = cnt_q;
    assign init_done_o = run;
`else
    assign run         = 1'b1;
    assign init_wr     = 1'b0;
    assign init_addr   = '0;
    assign init_done_o = 1'b1;
`endif

    // Grant: a lone request wins; on a tie the requester not granted last time wins
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst_i && run) begin
            if (req0_i && req1_i) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = req0_i;
                gnt1 = req1_i;
            end
        end
    end

    assign gnt0_o = gnt0;
    assign gnt1_o = gnt1;

    // RAM port mux; idle cycles keep address/data stable so dout does not move
    always_comb begin
        ram_we_o   = 1'b0;
        ram_addr_o = ram_addr_q;
        ram_din_o  = ram_din_q;
        if (rst_i) begin
            ram_addr_o = '0;
            ram_din_o  = '0;
        end else if (init_wr) begin
            ram_we_o   = 1'b1;
            ram_addr_o = init_addr;
            ram_din_o  = INIT_VALUE;
        end else if (gnt0) begin
            ram_we_o   = we0_i;
            ram_addr_o = addr0_i;
            ram_din_o  = wdata0_i;
        end else if (gnt1) begin
            ram_we_o   = we1_i;
            ram_addr_o = addr1_i;
            ram_din_o  = wdata1_i;
        end
    end

    // Round-robin pointer, read-in-flight tracking and RAM drive hold registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            last_q     <= 1'b1;
            pend_vld_q <= 1'b0;
            pend_id_q  <= 1'b0;
            ram_addr_q <= '0;
            ram_din_q  <= '0;
        end else begin
            if (gnt0) begin
                last_q <= 1'b0;
            end else if (gnt1) begin
                last_q <= 1'b1;
            end
            pend_vld_q <= (gnt0 & ~we0_i) | (gnt1 & ~we1_i);
            pend_id_q  <= gnt1;
            ram_addr_q <= ram_addr_o;
            ram_din_q  <= ram_din_o;
        end
    end

    // Read return: RAM dout is valid one edge after the address was captured
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            rvalid0_q <= pend_vld_q & ~pend_id_q;
            rvalid1_q <= pend_vld_q & pend_id_q;
            if (pend_vld_q && !pend_id_q) begin
                rdata0_q <= ram_dout_i;
            end
            if (pend_vld_q && pend_id_q) begin
                rdata1_q <= ram_dout_i;
            end
        end
    end

    assign rvalid0_o = rvalid0_q;
    assign rvalid1_o = rvalid1_q;
    assign rdata0_o  = rdata0_q;
    assign rdata1_o  = rdata1_q;

endmodule

// File: tb/tb_ram_dp_port_arbiter.sv
// Self-checking bench for ram_dp_port_arbiter. A behavioural registered-address
// RAM sits on the arbiter port. A negedge monitor predicts grants, RAM writes
// and init_done from its own arbitration model, pushes expected read results
// into a scoreboard queue on every predicted read acceptance, and pops/compares
// them when they fall due. Define RAM_ARB_INIT_EN to build with the clear feature.
`timescale 1ns/1ps
module tb_ram_dp_port_arbiter;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam logic [DW-1:0] InitVal = 32'h0000_0000;
`ifdef RAM_ARB_INIT_EN
    localparam logic InitDoneRst = 1'b0;
`else
    localparam logic InitDoneRst = 1'b1;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
    logic [AW-1:0] addr0 = '0, addr1 = '0;
    logic [DW-1:0] wdata0 = '0, wdata1 = '0;
    logic          gnt0, gnt1, rvalid0, rvalid1, init_done, ram_we;
    logic [DW-1:0] rdata0, rdata1, ram_din, ram_dout;
    logic [AW-1:0] ram_addr;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ram_dp_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .INIT_VALUE (InitVal)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req0_i      (req0),
        .we0_i       (we0),
        .addr0_i     (addr0),
        .wdata0_i    (wdata0),
        .gnt0_o      (gnt0),
        .rvalid0_o   (rvalid0),
        .rdata0_o    (rdata0),
        .req1_i      (req1),
        .we1_i       (we1),
        .addr1_i     (addr1),
        .wdata1_i    (wdata1),
        .gnt1_o      (gnt1),
        .rvalid1_o   (rvalid1),
        .rdata1_o    (rdata1),
        .init_done_o (init_done),
        .ram_we_o    (ram_we),
        .ram_addr_o  (ram_addr),
        .ram_din_o   (ram_din),
        .ram_dout_i  (ram_dout)
    );

    // Registered-address RAM: address and write captured on the rising edge
    logic [DW-1:0] ram_mem [0:(1<<AW)-1];
    logic [AW-1:0] ram_addr_reg;
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_din;
        ram_addr_reg <= ram_addr;
    end
    assign ram_dout = ram_mem[ram_addr_reg];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard of expected read returns
    typedef struct {
        logic          id;
        logic [DW-1:0] data;
        int            due;
    } exp_t;
    exp_t sb[$];

    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    int            cyc        = 0;
    int            init_cnt_m = 0;
    logic          last_m     = 1'b1;

    always @(negedge clk) begin : monitor
        logic ev0, ev1, eg0, eg1, edone, ewe;
        exp_t e;
        ev0 = 1'b0;
        ev1 = 1'b0;
        e   = '{id: 1'b0, data: '0, due: 0};
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e   = sb.pop_front();
            ev0 = ~e.id;
            ev1 = e.id;
        end
        if (ev0 || rvalid0) check_eq("rvalid0", 32'(rvalid0), 32'(ev0));
        if (ev0) check_eq("rdata0", rdata0, e.data);
        if (ev1 || rvalid1) check_eq("rvalid1", 32'(rvalid1), 32'(ev1));
        if (ev1) check_eq("rdata1", rdata1, e.data);

`ifdef RAM_ARB_INIT_EN
        edone = (init_cnt_m >= 1024);
`else
        edone = 1'b1;
`endif
        eg0 = 1'b0;
        eg1 = 1'b0;
        if (!rst && edone) begin
            if (req0 && req1) begin
                eg0 = last_m;
                eg1 = ~last_m;
            end else begin
                eg0 = req0;
                eg1 = req1;
            end
        end
        check_eq("gnt0", 32'(gnt0), 32'(eg0));
        check_eq("gnt1", 32'(gnt1), 32'(eg1));

        if (rst) begin
            sb.delete();
            last_m     = 1'b1;
            init_cnt_m = 0;
        end else begin
            check_eq("init_done", 32'(init_done), 32'(edone));
            ewe = ~edone | (eg0 & we0) | (eg1 & we1);
            check_eq("ram_we", 32'(ram_we), 32'(ewe));
            if (!edone) begin
                check_eq("init_addr", 32'(ram_addr), 32'(init_cnt_m));
                ref_mem[init_cnt_m[AW-1:0]] = InitVal;
                init_cnt_m++;
            end
            if (eg0) begin
                last_m = 1'b0;
                if (we0) ref_mem[addr0] = wdata0;
                else sb.push_back('{id: 1'b0, data: ref_mem[addr0], due: cyc + 2});
            end
            if (eg1) begin
                last_m = 1'b1;
                if (we1) ref_mem[addr1] = wdata1;
                else sb.push_back('{id: 1'b1, data: ref_mem[addr1], due: cyc + 2});
            end
        end
        cyc++;
    end

    // Drive both requesters for one cycle, then step past the next rising edge
    task automatic drive(input logic r0, input logic w0, input logic [AW-1:0] a0,
                         input logic [DW-1:0] d0, input logic r1, input logic w1,
                         input logic [AW-1:0] a1, input logic [DW-1:0] d1);
        req0 = r0; we0 = w0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; addr1 = a1; wdata1 = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0);
    endtask

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int n;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rvalid0", 32'(rvalid0), 32'd0);
        check_eq("rst_rvalid1", 32'(rvalid1), 32'd0);
        check_eq("rst_rdata0", rdata0, 32'd0);
        check_eq("rst_rdata1", rdata1, 32'd0);
        check_eq("rst_ram_we", 32'(ram_we), 32'd0);
        check_eq("rst_ram_addr", 32'(ram_addr), 32'd0);
        check_eq("rst_ram_din", ram_din, 32'd0);
        check_eq("rst_init_done", 32'(init_done), 32'(InitDoneRst));
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef RAM_ARB_INIT_EN
        // Request held through the clear; granted on the first RUN cycle
        req0 = 1'b1; we0 = 1'b0; addr0 = 10'h3FF;
        n = 0;
        while (n < 1200) begin
            @(negedge clk);
            n++;
            if (gnt0) break;
        end
        check_eq("gnt0_after_init", 32'(gnt0), 32'd1);
        check_eq("init_len", 32'(n), 32'd1025);
        @(posedge clk);
        #1;
        req0 = 1'b0;
        idle(3);
`endif

        // Write by 0 then read of the same address by 1 on the next cycle
        drive(1'b1, 1'b1, 10'h005, 32'hDEAD_BEEF, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h005, '0);
        idle(4);

        // Preload, then both requesters read continuously: grants must alternate
        drive(1'b1, 1'b1, 10'h010, 32'h1111_0010, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b1, 10'h020, 32'h2222_0020);
        for (int i = 0; i < 8; i++)
            drive(1'b1, 1'b0, 10'h010, '0, 1'b1, 1'b0, 10'h020, '0);
        idle(4);

        // Full-array random writes by 0, then back-to-back reads by 1
        for (int i = 0; i < 1024; i++)
            drive(1'b1, 1'b1, AW'(i), $urandom, 1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 1024; i++)
            drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, AW'(i), '0);
        idle(4);

        // Reset right after a read is accepted: no response, read data cleared
        drive(1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0);
        req0 = 1'b0;
        rst  = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("rstrd_rvalid0", 32'(rvalid0), 32'd0);
        check_eq("rstrd_rvalid1", 32'(rvalid1), 32'd0);
        check_eq("rstrd_rdata0", rdata0, 32'd0);
        check_eq("rstrd_rdata1", rdata1, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

`ifdef RAM_ARB_INIT_EN
        // Reset in the middle of the clear restarts it from address 0
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n = 0;
        while (n < 2000) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (init_done) break;
        end
        check_eq("reinit_len", 32'(n), 32'd1024);
        @(posedge clk);
        #1;
`else
        idle(2);
`endif

        // Post-reset read: cleared value with the feature, kept data without
        drive(1'b1, 1'b0, 10'h010, '0, 1'b0, 1'b0, '0, '0);
        drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0, 10'h005, '0);
        idle(4);
        check_eq("sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
